uart_tx_fifo: RTL and testbench

//  Configurable UART transmitter with an integrated TX FIFO; successor to the

---
 rtl/uart_tx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with an integrated TX FIFO. Frame format is chosen at
//   runtime (5-8 data bits, none/odd/even/mark parity, 1 or 2 stop bits) and
//   captured when a byte leaves the FIFO, so a reconfiguration never corrupts
//   a frame already on the wire. Bit timing comes from the shared baud clken.
//
//   Ports
//     clk, reset      system clock, asynchronous active-high reset
//     clken           baud tick, one cycle high per bit period
//     din, wr_en      byte to queue / push strobe
//     cfg_data_bits   0..3 -> 5..8 data bits
//     cfg_parity      0 none, 1 odd, 2 even, 3 mark
//     cfg_two_stop    1 = two stop bits
//     tx              serial output, idle high
//     tx_busy         FIFO non-empty or frame in progress
//     fifo_full       FIFO holds FIFO_DEPTH entries
//     fifo_empty      FIFO holds no entries
//     fifo_level      current occupancy
//     overflow        one-cycle pulse after a write was dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clken,
    input  logic [7:0]                  din,
    input  logic                        wr_en,
    input  logic [1:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_two_stop,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2
    } state_t;

    // Parity over the active data bits only; upper din bits are masked off.
    function automatic logic f_parity(input logic [7:0] data,
                                      input logic [1:0] nbits,
                                      input logic [1:0] mode);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - nbits);
        x    = ^(data & mask);
        case (mode)
            2'd1:    return ~x;
            2'd2:    return x;
            default: return 1'b1;
        endcase
    endfunction

    // FIFO storage and control
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic          w_push;
    logic          w_pop;

    // Frame FSM and per-frame latched configuration
    state_t        r_state,  w_state_nx;
    logic [7:0]    r_data,   w_data_nx;
    logic [2:0]    r_bitpos, w_bitpos_nx;
    logic [1:0]    r_dbits,  w_dbits_nx;
    logic [1:0]    r_par,    w_par_nx;
    logic          r_two,    w_two_nx;
    logic          r_tx,     w_tx_nx;

    assign fifo_full  = (r_level == FULL_LEVEL);
    assign fifo_empty = (r_level == '0);
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign tx         = r_tx;
    assign tx_busy    = (r_state != S_IDLE) || !fifo_empty;

    assign w_push = wr_en && !fifo_full;
    // The FSM pops whenever it is idle and data is waiting.
    assign w_pop  = (r_state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Uses the pre-pop full flag: a pop in the same cycle does not
            // rescue the write.
            r_overflow <= wr_en && fifo_full;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_data_nx   = r_data;
        w_bitpos_nx = r_bitpos;
        w_dbits_nx  = r_dbits;
        w_par_nx    = r_par;
        w_two_nx    = r_two;
        w_tx_nx     = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (!fifo_empty) begin
                    w_data_nx   = r_mem[r_rd_ptr];
                    w_dbits_nx  = cfg_data_bits;
                    w_par_nx    = cfg_parity;
                    w_two_nx    = cfg_two_stop;
                    w_bitpos_nx = 3'd0;
                    w_state_nx  = S_START;
                end
            end
            S_START: begin
                if (clken) begin
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (clken) begin
                    w_tx_nx = r_data[r_bitpos];
                    // Last data bit index is 4 + r_dbits, i.e. {1, r_dbits}.
                    if (r_bitpos == {1'b1, r_dbits}) begin
                        w_state_nx = (r_par != 2'd0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bitpos_nx = r_bitpos + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (clken) begin
                    w_tx_nx    = f_parity(r_data, r_dbits, r_par);
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (clken) begin
                    w_tx_nx    = 1'b1;
                    w_state_nx = r_two ? S_STOP2 : S_IDLE;
                end
            end
            S_STOP2: begin
                if (clken) begin
                    w_tx_nx    = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_bitpos <= 3'd0;
        end else begin
            r_state  <= w_state_nx;
            r_tx     <= w_tx_nx;
            r_bitpos <= w_bitpos_nx;
        end
    end

    // Frame payload and format only matter once the FSM has left IDLE.
    always_ff @(posedge clk) begin
        r_data  <= w_data_nx;
        r_dbits <= w_dbits_nx;
        r_par   <= w_par_nx;
        r_two   <= w_two_nx;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clken;
    logic [7:0]    din;
    logic          wr_en;
    logic [1:0]    cfg_data_bits;
    logic [1:0]    cfg_parity;
    logic          cfg_two_stop;
    logic          tx;
    logic          tx_busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    always #5 clk = ~clk;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clken(clken), .din(din), .wr_en(wr_en),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
        .cfg_two_stop(cfg_two_stop), .tx(tx), .tx_busy(tx_busy),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    // bits[0] is the first bit on the wire (start bit)
    typedef struct {
        logic [0:11] bits;
        int          len;
    } frame_t;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  nb;
        logic [1:0]  par;
        logic        two;
        logic [0:11] exp;
        int          len;
    } vec_t;

    frame_t sb[$];
    frame_t cur;
    bit     mon_active;
    int     idx;
    int     tick;
    int     frames_seen;
    int     start_ticks[$];
    int     n_chk;
    int     n_fail;
    bit     ce_en;
    int     div;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame builder
    function automatic frame_t model(input logic [7:0] d, input logic [1:0] nb,
                                     input logic [1:0] par, input logic two);
        frame_t f;
        int     ones;
        int     n;
        f.bits = '0;
        f.len  = 1;
        ones   = 0;
        n      = 5 + int'(nb);
        for (int i = 0; i < n; i++) begin
            f.bits[f.len] = d[i];
            ones += int'(d[i]);
            f.len++;
        end
        if (par != 2'd0) begin
            if (par == 2'd3)      f.bits[f.len] = 1'b1;
            else if (par == 2'd2) f.bits[f.len] = (ones % 2 == 1);
            else                  f.bits[f.len] = (ones % 2 == 0);
            f.len++;
        end
        f.bits[f.len] = 1'b1;
        f.len++;
        if (two) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    // Observes tx on every baud tick and compares frames against the scoreboard.
    task automatic mon(input bit ce, input bit rs);
        if (rs) begin
            mon_active = 1'b0;
            sb.delete();
        end else if (ce) begin
            tick++;
            if (!mon_active && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at tick %0d, expected no frame", tick);
                end else begin
                    cur        = sb.pop_front();
                    mon_active = 1'b1;
                    idx        = 0;
                    start_ticks.push_back(tick);
                    frames_seen++;
                end
            end
            if (mon_active) begin
                chk($sformatf("frame%0d_bit%0d", frames_seen, idx), 32'(tx), 32'(cur.bits[idx]));
                idx++;
                if (idx == cur.len) mon_active = 1'b0;
            end
        end
    endtask

    // One clock: sample after the rising edge, then drive the baud tick at the falling edge.
    task automatic step();
        bit ce_s;
        bit rs_s;
        @(posedge clk);
        ce_s = clken;
        rs_s = reset;
        #1;
        mon(ce_s, rs_s);
        @(negedge clk);
        div   = (div + 1) % 4;
        clken = ce_en && (div == 0);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit expect_tx);
        frame_t f;
        din   = d;
        wr_en = 1'b1;
        if (expect_tx) begin
            f = model(d, cfg_data_bits, cfg_parity, cfg_two_stop);
            sb.push_back(f);
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mon_active) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            step();
            n++;
        end
        chk("frame_wait_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[6];
        frame_t f;
        int     base;
        int     st0;
        int     ov_cnt;
        int     t0;
        int     n;

        reset = 1'b1; clken = 1'b0; wr_en = 1'b0; din = '0;
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_two_stop = 1'b0;
        ce_en = 1'b0; div = 0; n_chk = 0; n_fail = 0;
        tick = 0; frames_seen = 0; mon_active = 1'b0; idx = 0;

        vecs[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 12'b0101_0010_1100, 10}; // 8N1
        vecs[1] = '{8'h41, 2'd2, 2'd2, 1'b0, 12'b0100_0001_0100, 10}; // 7E1
        vecs[2] = '{8'h13, 2'd0, 2'd1, 1'b1, 12'b0110_0101_1000,  9}; // 5O2
        vecs[3] = '{8'h00, 2'd3, 2'd3, 1'b1, 12'b0000_0000_0111, 12}; // 8M2
        vecs[4] = '{8'hFF, 2'd1, 2'd2, 1'b0, 12'b0111_1110_1000,  9}; // 6E1, upper bits masked
        vecs[5] = '{8'hC0, 2'd2, 2'd1, 1'b0, 12'b0000_0001_0100, 10}; // 7O1, bit 7 excluded

        repeat (3) step();
        chk("rst_tx",       32'(tx),         32'd1);
        chk("rst_busy",     32'(tx_busy),    32'd0);
        chk("rst_full",     32'(fifo_full),  32'd0);
        chk("rst_empty",    32'(fifo_empty), 32'd1);
        chk("rst_level",    32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        reset = 1'b0;
        step();

        // Table vectors; cfg is scrambled after the pop to show it was latched.
        ce_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cfg_data_bits = vecs[i].nb;
            cfg_parity    = vecs[i].par;
            cfg_two_stop  = vecs[i].two;
            f.bits = vecs[i].exp;
            f.len  = vecs[i].len;
            sb.push_back(f);
            din   = vecs[i].d;
            wr_en = 1'b1;
            step();
            wr_en = 1'b0;
            step();
            cfg_data_bits = ~vecs[i].nb;
            cfg_parity    = ~vecs[i].par;
            cfg_two_stop  = ~vecs[i].two;
            wait_idle(2000);
            chk($sformatf("vec%0d_busy_after", i), 32'(tx_busy), 32'd0);
            chk($sformatf("vec%0d_tx_idle", i),    32'(tx),      32'd1);
        end
        chk("table_frames", 32'(frames_seen), 32'd6);

        // Overflow: first byte parks in the shifter (no clken), then 9 writes.
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_two_stop = 1'b0;
        ce_en = 1'b0;
        step();
        base = frames_seen;
        write_byte(8'h11, 1'b1);
        step();
        chk("ovf_shifter_empty", 32'(fifo_empty), 32'd1);
        chk("ovf_shifter_busy",  32'(tx_busy),    32'd1);
        ov_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            write_byte(8'h20 + 8'(i), (i < 8));
            ov_cnt += int'(overflow);
        end
        repeat (3) begin
            step();
            ov_cnt += int'(overflow);
        end
        chk("ovf_pulses", 32'(ov_cnt),     32'd1);
        chk("ovf_level",  32'(fifo_level), 32'd8);
        chk("ovf_full",   32'(fifo_full),  32'd1);
        chk("ovf_empty",  32'(fifo_empty), 32'd0);
        ce_en = 1'b1;
        wait_idle(4000);
        repeat (160) step();
        chk("ovf_frames", 32'(frames_seen - base), 32'd9);
        chk("ovf_drained_level", 32'(fifo_level), 32'd0);
        chk("ovf_drained_busy",  32'(tx_busy),    32'd0);

        // Back-to-back frames: start bits exactly one frame (10 ticks) apart.
        base = frames_seen;
        st0  = start_ticks.size();
        write_byte(8'h3C, 1'b1);
        write_byte(8'hF0, 1'b1);
        write_byte(8'h81, 1'b1);
        wait_frames(base + 3, 800);
        chk("b2b_empty_after_pop", 32'(fifo_empty), 32'd1);
        wait_idle(800);
        n = start_ticks.size() - st0;
        chk("b2b_frames", 32'(n), 32'd3);
        if (n >= 3) begin
            chk("b2b_gap1", 32'(start_ticks[st0+1] - start_ticks[st0]),   32'd10);
            chk("b2b_gap2", 32'(start_ticks[st0+2] - start_ticks[st0+1]), 32'd10);
        end

        // Reset during the data bits of frame 2 of 3.
        base = frames_seen;
        write_byte(8'hFF, 1'b1);
        write_byte(8'h00, 1'b1);
        write_byte(8'hAA, 1'b1);
        wait_frames(base + 2, 800);
        t0 = tick;
        n  = 0;
        while (tick < t0 + 3 && n < 100) begin
            step();
            n++;
        end
        chk("midrst_tx_before", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_tx",    32'(tx),         32'd1);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_empty", 32'(fifo_empty), 32'd1);
        chk("midrst_busy",  32'(tx_busy),    32'd0);
        repeat (2) step();
        reset = 1'b0;
        repeat (200) step();
        chk("midrst_no_frames", 32'(frames_seen - base), 32'd2);
        chk("midrst_tx_idle",   32'(tx),                 32'd1);
        chk("midrst_busy_idle", 32'(tx_busy),            32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
